// File: rtl/bus_arbiter_16.sv
// bus_arbiter_16 -- two-requester round-robin arbiter in front of one
// registered 16-bit output slot with valid/ready handshakes on every port.
//
// Optional feature: define ARB_FIXED_PRIO_EN to make requester 0 win every
// contention. last_grant still tracks the most recent winner either way.
//
// The output slot is a two-state FSM (EMPTY/FULL). The request-side ready
// signals are combinational so that a free slot can be refilled in the same
// cycle it drains, which gives one word per cycle under a permanently ready
// sink.

module bus_arbiter_16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [15:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [15:0] req1_data,
    output logic        req1_ready,
    output logic        out_valid,
    output logic [15:0] out_data,
    input  logic        out_ready,
    output logic        sel,
    output logic        last_grant
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_t;

    slot_state_t state_r;
    slot_state_t state_nx_s;
    logic [15:0] data_r;
    logic [15:0] data_nx_s;
    logic        sel_r;
    logic        sel_nx_s;
    logic        last_grant_r;
    logic        last_grant_nx_s;

    logic        slot_free_s;
    logic        any_valid_s;
    logic        winner_s;
    logic        xfer_s;
    logic        grant0_s;
    logic        grant1_s;

    // Winner under contention: fixed priority build always picks requester 0,
    // round-robin build picks the requester that was not served last.
    function automatic logic contention_winner(input logic last_g);
`ifdef ARB_FIXED_PRIO_EN
        contention_winner = 1'b0;
`else
        contention_winner = ~last_g;
`endif
    endfunction

    // Arbitration decision and handshake: evaluated fresh every cycle, so a
    // requester that withdraws before its transfer simply drops out.
    always_comb begin
        slot_free_s = (state_r == ST_EMPTY) || out_ready;
        any_valid_s = req0_valid || req1_valid;
        winner_s    = 1'b0;
        if (req0_valid && req1_valid) begin
            winner_s = contention_winner(last_grant_r);
        end else if (req1_valid) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
        // Ready stays low while reset is asserted so nothing is promised to a
        // requester that the (cleared) slot would then drop.
        xfer_s   = slot_free_s && any_valid_s && rst_n;
        grant0_s = xfer_s && (winner_s == 1'b0);
        grant1_s = xfer_s && (winner_s == 1'b1);
    end

    // Next-state and next-data for the output slot.
    always_comb begin
        state_nx_s      = state_r;
        data_nx_s       = data_r;
        sel_nx_s        = sel_r;
        last_grant_nx_s = last_grant_r;
        case (state_r)
            ST_EMPTY: begin
                if (xfer_s) begin
                    state_nx_s = ST_FULL;
                end else begin
                    state_nx_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (xfer_s) begin
                    state_nx_s = ST_FULL;
                end else if (out_ready) begin
                    state_nx_s = ST_EMPTY;
                end else begin
                    state_nx_s = ST_FULL;
                end
            end
            default: begin
                state_nx_s = ST_EMPTY;
            end
        endcase
        if (xfer_s) begin
            data_nx_s       = winner_s ? req1_data : req0_data;
            sel_nx_s        = winner_s;
            last_grant_nx_s = winner_s;
        end else begin
            data_nx_s       = data_r;
            sel_nx_s        = sel_r;
            last_grant_nx_s = last_grant_r;
        end
    end

    // Slot registers; reset empties the slot and points the round-robin
    // pointer at requester 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_EMPTY;
            data_r       <= 16'h0000;
            sel_r        <= 1'b0;
            last_grant_r <= 1'b1;
        end else begin
            state_r      <= state_nx_s;
            data_r       <= data_nx_s;
            sel_r        <= sel_nx_s;
            last_grant_r <= last_grant_nx_s;
        end
    end

    // Port drive: sink-side outputs come straight from registers.
    always_comb begin
        out_valid  = (state_r == ST_FULL);
        out_data   = data_r;
        sel        = sel_r;
        last_grant = last_grant_r;
        req0_ready = grant0_s;
        req1_ready = grant1_s;
    end

endmodule

// File: doc/bus_arbiter_16.md
BUS_ARBITER_16 -- requirements
Module: bus_arbiter_16

Interface
REQ-001 The block SHALL have exactly one clock and use an asynchronous, active-low reset.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: req0_valid  input  1  requester 0 has a word to send.
REQ-005 Port: req0_data  input  16  requester 0 word.
REQ-006 Port: req0_ready  output  1  requester 0 word is taken this cycle.
REQ-007 Port: req1_valid / req1_data / req1_ready  input 1 / input 16 / output 1  same as requester 0, for requester 1.
REQ-008 Port: out_valid  output  1  out_data holds a word for the sink.
REQ-009 Port: out_data  output  16  registered word for the shared sink.
REQ-010 Port: out_ready  input  1  sink accepts out_data this cycle.
REQ-011 Port: sel  output  1  source of the word in out_data (0 = req0, 1 = req1); drives the 16-bit 2:1 selector's select input.
REQ-012 Port: last_grant  output  1  round-robin pointer, the requester served most recently.

Function
REQ-013 Transfer rule: a word moves on a rising edge when valid and ready are both high; the same rule applies on every port.
REQ-014 Slot free: the output register SHALL be free when out_valid=0, or when out_valid=1 and out_ready=1.
REQ-015 Arbitration: while the slot is free, exactly one of req0_ready/req1_ready SHALL be driven high, combinationally, for the winning valid requester; both SHALL be low otherwise.
REQ-016 Winner: if only one requester is valid, it wins; if both are valid, the requester not equal to last_grant wins.
REQ-017 Capture: on a transfer, out_data <= winner's data, sel <= winner index, last_grant <= winner index, and out_valid <= 1. Latency from request acceptance to out_valid is one cycle.
REQ-018 Output draining: if the sink accepts with no new transfer, out_valid <= 0; out_data and sel hold their values.
REQ-019 Throughput: a sink that holds out_ready high SHALL receive one word per cycle with no bubbles while any requester is valid.
REQ-020 Back-pressure: while out_valid=1 and out_ready=0, both req*_ready SHALL be 0, and out_data, sel and out_valid SHALL be stable.
REQ-021 Neither requester valid: no state SHALL change except draining per REQ-018.
REQ-022 Requester withdrawal: a requester that deasserts valid before its transfer loses nothing; the decision is re-evaluated every cycle.
REQ-023 Fairness: with both requesters continuously valid and out_ready=1, grants SHALL alternate 0,1,0,1.

Reset
REQ-024 Asserting rst_n low SHALL immediately force out_valid=0, out_data=16'h0000, sel=0 and last_grant=1, so that requester 0 wins the first contention.
REQ-025 Reset asserted mid-transfer SHALL discard any held word; req*_ready SHALL be 0 while rst_n is low.
REQ-026 Release of rst_n SHALL take effect on the first rising clk edge after release; no transfer occurs on that edge unless the handshake is satisfied.

Configuration
REQ-027 Macro ARB_FIXED_PRIO_EN: when defined, contention SHALL always be won by requester 0, and last_grant SHALL still update per REQ-017.
REQ-028 When ARB_FIXED_PRIO_EN is undefined, the round-robin winner rule REQ-016 applies.
REQ-029 All other behaviour SHALL be identical with and without ARB_FIXED_PRIO_EN.

Verification
REQ-030 Reset: hold rst_n=0 -> out_valid=0, out_data=16'h0000, sel=0, last_grant=1; release with req0_valid=1, req0_data=16'hAAAA, out_ready=1 -> next edge out_data=16'hAAAA, sel=0.
REQ-031 Contention: req0=16'hAAAA and req1=16'hBBBB both valid, out_ready=1 for 4 cycles -> out_data AAAA, BBBB, AAAA, BBBB and sel 0,1,0,1 (with ARB_FIXED_PRIO_EN: AAAA every cycle, sel=0).
REQ-032 Back-pressure: out_valid=1 holding 16'hBBBB, out_ready=0 for 3 cycles, both requesters valid -> req0_ready=req1_ready=0, out_data stays BBBB; out_ready=1 -> requester 0 is granted the same cycle.
REQ-033 Single requester: only req1_valid=1, data 16'h1234 -> req1_ready=1 with the slot free, out_data=16'h1234 and sel=1 one cycle later, last_grant=1.
REQ-034 Drain/idle: one word accepted with no new requests -> out_valid falls to 0 after the sink accepts, and out_data is unchanged.
REQ-035 Mid-operation reset: pull rst_n low while out_valid=1 and out_ready=0, without a clock edge -> out_valid=0 immediately, and the held word never appears after release.
